// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared serial frame constants and state encoding for the receive and transmit sides
package receiver_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/receiver.sv
// rtl/receiver.sv - 7E1 serial frame receiver sampling the line once per clk, with a one-frame output buffer
module receiver
  import receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [2:0] IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] DATA      = 3'(ST_DATA);
  localparam logic [2:0] PARITY    = 3'(ST_PARITY);
  localparam logic [2:0] STOP      = 3'(ST_STOP);
  localparam logic [2:0] WAIT_HIGH = 3'(ST_WAIT_HIGH);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A completing frame in STOP below overrides this clear.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!serial_in) begin
            state <= DATA;
            cnt   <= 3'd0;
          end
        end

        DATA: begin
          shreg <= {serial_in, shreg[DATA_BITS-1:1]};
          if (cnt == LAST_BIT) begin
            cnt   <= 3'd0;
            state <= PARITY;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        PARITY: begin
          perr_q <= serial_in ^ (^shreg);
          state  <= STOP;
        end

        STOP: begin
          if (!valid || ready) begin
            data_out   <= shreg;
            parity_err <= perr_q;
            frame_err  <= ~serial_in;
            valid      <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= serial_in ? IDLE : WAIT_HIGH;
        end

        // A broken stop bit leaves the line low; wait for it to idle before hunting a start bit.
        WAIT_HIGH: begin
          if (serial_in) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - randomized and directed bench for receiver against a frame-level buffer model
module tb_receiver;
  import receiver_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 serial_in = 1'b1;
  logic                 ready = 1'b0;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  receiver dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  int rmode   = 1;

  // What the generator knows about the bit currently on the line.
  bit       cur_done = 1'b0;
  bit [6:0] cur_d    = '0;
  bit       cur_pe   = 1'b0;
  bit       cur_fe   = 1'b0;

  // Frame-level model of the output buffer.
  bit       m_valid = 1'b0;
  bit [6:0] m_d     = '0;
  bit       m_pe    = 1'b0;
  bit       m_fe    = 1'b0;
  bit       m_ovr   = 1'b0;

  int cyc        = 0;
  int last_vrise = 0;
  int vrise_gap  = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_d     <= '0;
      m_pe    <= 1'b0;
      m_fe    <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      m_ovr <= 1'b0;
      if (cur_done) begin
        if (!m_valid || ready) begin
          m_valid <= 1'b1;
          m_d     <= cur_d;
          m_pe    <= cur_pe;
          m_fe    <= cur_fe;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid && !prev_valid) begin
      vrise_gap  = cyc - last_vrise;
      last_vrise = cyc;
    end
    prev_valid = valid;
    if (chk_en) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) begin
        chk("data_out", 32'(data_out), 32'(m_d));
        chk("parity_err", 32'(parity_err), 32'(m_pe));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
      end
    end
  end

  task automatic drive(input bit b, input bit done, input bit [6:0] d, input bit pe, input bit fe);
    @(negedge clk);
    serial_in = b;
    case (rmode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
    cur_done = done;
    cur_d    = d;
    cur_pe   = pe;
    cur_fe   = fe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bit [6:0] d, input bit flip, input bit stop);
    bit p;
    p = (^d) ^ flip;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(d[i], 1'b0, '0, 1'b0, 1'b0);
    drive(p, 1'b0, '0, 1'b0, 1'b0);
    drive(stop, 1'b1, d, flip, ~stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [6:0] rd;
    bit       rflip;
    bit       rstop;

    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Clean frame 0x41
    rmode = 1;
    send_frame(7'h41, 1'b0, 1'b1);
    idle(1);
    chk("clean_valid", 32'(valid), 32'd1);
    chk("clean_data", 32'(data_out), 32'h41);
    chk("clean_perr", 32'(parity_err), 32'd0);
    chk("clean_ferr", 32'(frame_err), 32'd0);
    idle(1);
    chk("clean_drained", 32'(valid), 32'd0);

    // Parity error on 0x55
    send_frame(7'h55, 1'b1, 1'b1);
    idle(1);
    chk("par_data", 32'(data_out), 32'h55);
    chk("par_perr", 32'(parity_err), 32'd1);
    chk("par_ferr", 32'(frame_err), 32'd0);
    idle(2);

    // Framing error on 0x12, line low for 4 more cycles
    send_frame(7'h12, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("fe_ferr", 32'(frame_err), 32'd1);
    chk("fe_data", 32'(data_out), 32'h12);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("fe_no_frame", 32'(valid), 32'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    send_frame(7'h33, 1'b0, 1'b1);
    idle(1);
    chk("fe_next_data", 32'(data_out), 32'h33);
    chk("fe_next_ferr", 32'(frame_err), 32'd0);
    idle(2);

    // Overrun: 0x01 then 0x7F with nobody consuming
    rmode = 0;
    send_frame(7'h01, 1'b0, 1'b1);
    send_frame(7'h7F, 1'b0, 1'b1);
    idle(1);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_data", 32'(data_out), 32'h01);
    idle(1);
    chk("ovr_pulse_end", 32'(overrun), 32'd0);
    chk("ovr_held", 32'(data_out), 32'h01);
    rmode = 1;
    idle(2);
    chk("ovr_drained", 32'(valid), 32'd0);

    // Reset after d3 of a frame
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rstn      = 1'b0;
    serial_in = 1'b1;
    cur_done  = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    idle(2);
    rstn = 1'b1;
    send_frame(7'h2A, 1'b0, 1'b1);
    idle(1);
    chk("post_rst_valid", 32'(valid), 32'd1);
    chk("post_rst_data", 32'(data_out), 32'h2A);
    chk("post_rst_perr", 32'(parity_err), 32'd0);
    chk("post_rst_ferr", 32'(frame_err), 32'd0);
    idle(2);

    // Back-to-back 0x00 then 0x7F
    send_frame(7'h00, 1'b0, 1'b1);
    send_frame(7'h7F, 1'b0, 1'b1);
    idle(1);
    chk("b2b_data", 32'(data_out), 32'h7F);
    chk("b2b_gap", 32'(vrise_gap), 32'd10);
    idle(2);

    // Random traffic
    rmode = 2;
    for (int n = 0; n < 200; n++) begin
      rd    = 7'($urandom);
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rflip, rstop);
      if (!rstop) begin
        for (int k = 0; k < int'($urandom_range(0, 5)); k++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      end
      idle(int'($urandom_range(0, 2)));
    end
    rmode = 1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
